// File: rtl/stw_test_sequencer.sv
// stw_test_sequencer: drives the self-test-while-working port of a row of MAC PEs.
// Walks a built-in table of MAC test vectors and broadcasts operands plus the golden
// result to every PE. It then pulses STW_start, waits for all PEs to complete, and
// accumulates the failing PEs into a sticky fault_map.
//
// Optional feature: define STW_SEQ_TIMEOUT_EN to bound WAIT_DONE to TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall               memory stall, honoured in LOAD/START only
//   start               run request, sampled in IDLE only
//   busy, done          run in progress / one-cycle run-finished pulse
//   fault_map           per-PE sticky failure bits; any_fault = |fault_map
//   timeout_flag        a WAIT_DONE timeout occurred this run
//   STW_test_load_en    PE operand load strobe
//   STW_mult_op1/op2    broadcast multiplier operands
//   STW_add_op          broadcast addend
//   STW_expected        golden (op1*op2+add) mod 2^WORD_SIZE
//   STW_start           broadcast test start pulse
//   STW_complete        per-PE complete (high = idle/finished)
//   STW_result_out      per-PE pass(1)/fail(0)
module stw_test_sequencer #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned NUM_PE         = 4,
    parameter int unsigned NUM_VECTORS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_PE-1:0]    fault_map,
    output logic                 any_fault,
    output logic                 timeout_flag,
    output logic                 STW_test_load_en,
    output logic [WORD_SIZE-1:0] STW_mult_op1,
    output logic [WORD_SIZE-1:0] STW_mult_op2,
    output logic [WORD_SIZE-1:0] STW_add_op,
    output logic [WORD_SIZE-1:0] STW_expected,
    output logic                 STW_start,
    input  logic [NUM_PE-1:0]    STW_complete,
    input  logic [NUM_PE-1:0]    STW_result_out
);

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] op1;
        logic [WORD_SIZE-1:0] op2;
        logic [WORD_SIZE-1:0] add;
    } vec_t;

    // Built-in test vector table; constants are masked to WORD_SIZE
    function automatic vec_t vec_lookup(input logic [IDX_W-1:0] i);
        vec_t v;
        v.op1 = '0;
        v.op2 = '0;
        v.add = '0;
        case (i)
            3'd0: ;
            3'd1: begin v.op1 = '1;                      v.op2 = WORD_SIZE'(1);          end
            3'd2: begin v.op1 = WORD_SIZE'(16'h5555);    v.op2 = WORD_SIZE'(2);          end
            3'd3: begin v.op1 = WORD_SIZE'(1);           v.op2 = WORD_SIZE'(1); v.add = '1; end
            3'd4: begin v.op1 = WORD_SIZE'(3);           v.op2 = WORD_SIZE'(5); v.add = WORD_SIZE'(7); end
            3'd5: begin v.op1 = WORD_SIZE'(16'h00FF);    v.op2 = WORD_SIZE'(16'h0101); v.add = WORD_SIZE'(1); end
            3'd6: begin v.op1 = WORD_SIZE'(16'hAAAA);    v.op2 = WORD_SIZE'(1); v.add = WORD_SIZE'(16'h5555); end
            default: begin v.op1 = WORD_SIZE'(16'h1234); v.add = WORD_SIZE'(16'h8000); end
        endcase
        return v;
    endfunction

    state_t                r_state, w_state_nx;
    logic [IDX_W-1:0]      r_idx, w_idx_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic [NUM_PE-1:0]     r_fault_map, w_fault_nx;
    logic                  r_timeout_flag, w_timeout_nx;
    logic                  w_load_vec;
    logic                  w_vec_end;
    vec_t                  w_vec;
    logic [WORD_SIZE-1:0]  w_exp;
    logic                  r_busy, r_done, r_any_fault, r_load_en, r_stw_start;
    logic [WORD_SIZE-1:0]  r_op1, r_op2, r_add, r_exp;

    // Next-state, counter and fault accumulation
    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_cnt_nx     = r_cnt;
        w_fault_nx   = r_fault_map;
        w_timeout_nx = r_timeout_flag;
        w_load_vec   = 1'b0;
        w_vec_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_fault_nx   = '0;
                    w_timeout_nx = 1'b0;
                    w_idx_nx     = '0;
                    w_load_vec   = 1'b1;
                    w_state_nx   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!stall) w_state_nx = ST_START;
            end
            ST_START: begin
                if (!stall) begin
                    w_state_nx = ST_WAIT_LOW;
                    w_cnt_nx   = '0;
                end
            end
            // PEs still report complete on the start edge; skip two cycles
            ST_WAIT_LOW: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = ST_WAIT_DONE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (&STW_complete) begin
                    w_fault_nx = r_fault_map | ~STW_result_out;
                    w_vec_end  = 1'b1;
                end
`ifdef STW_SEQ_TIMEOUT_EN
                // A PE that never completes is counted as failed
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_fault_nx   = r_fault_map | ~STW_complete | ~STW_result_out;
                    w_timeout_nx = 1'b1;
                    w_vec_end    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
`endif
                if (w_vec_end) begin
                    if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_load_vec = 1'b1;
                        w_state_nx = ST_LOAD;
                    end
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Operands and golden result for the vector about to be loaded
    always_comb begin
        w_vec = vec_lookup(w_idx_nx);
        w_exp = WORD_SIZE'(w_vec.op1 * w_vec.op2) + w_vec.add;
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_fault_map    <= '0;
            r_timeout_flag <= 1'b0;
            r_any_fault    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_load_en      <= 1'b0;
            r_stw_start    <= 1'b0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_add          <= '0;
            r_exp          <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_idx          <= w_idx_nx;
            r_cnt          <= w_cnt_nx;
            r_fault_map    <= w_fault_nx;
            r_timeout_flag <= w_timeout_nx;
            r_any_fault    <= |w_fault_nx;
            r_busy         <= (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);
            r_done         <= (w_state_nx == ST_DONE);
            r_load_en      <= (w_state_nx == ST_LOAD);
            // Single pulse on LOAD->START; stalled START cycles stay low
            r_stw_start    <= (w_state_nx == ST_START) && (r_state == ST_LOAD);
            if (w_load_vec) begin
                r_op1 <= w_vec.op1;
                r_op2 <= w_vec.op2;
                r_add <= w_vec.add;
                r_exp <= w_exp;
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign fault_map        = r_fault_map;
    assign any_fault        = r_any_fault;
    assign timeout_flag     = r_timeout_flag;
    assign STW_test_load_en = r_load_en;
    assign STW_start        = r_stw_start;
    assign STW_mult_op1     = r_op1;
    assign STW_mult_op2     = r_op2;
    assign STW_add_op       = r_add;
    assign STW_expected     = r_exp;

endmodule
